central_register_bank: RTL and testbench

Responder for the A07 service-gate outputs. Holds the central registers A, L, Q, Z and B and acts on the gate strobes produced during each time pulse:
- clear-gates (CxG) zero a register;
- write-gates (WxG_n) OR the write bus into it;
- read-gates (RxG_n) drive its contents onto the read bus.

It sits between the service gates and the write/read bus logic, replacing per-bit register modules with one clocked bank.

---
 rtl/central_register_bank.sv | 130 +++++++++++++
 tb/tb_central_register_bank.sv | 208 ++++++++++++++++++++
 2 files changed

// File: rtl/central_register_bank.sv
// Central register bank: A, L, Q, Z and B driven by the service-gate strobes.
// Clear, write-OR and read gates act per clock edge; reads are combinational.
module central_register_bank #(
    parameter int WIDTH = 16,
    parameter logic [WIDTH-1:0] Z_RESET = WIDTH'(16'o04000)
) (
    input  logic             SIM_CLK,
    input  logic             SIM_RST,
    input  logic             VCC,
    input  logic             GND,
    input  logic [WIDTH-1:0] WL_n,
    input  logic             CAG,
    input  logic             CQG,
    input  logic             CZG,
    input  logic             CBG,
    input  logic             CLG1G,
    input  logic             CLG2G,
    input  logic             WAG_n,
    input  logic             WLG_n,
    input  logic             WQG_n,
    input  logic             WZG_n,
    input  logic             WBG_n,
    input  logic             WALSG_n,
    input  logic             RAG_n,
    input  logic             RLG_n,
    input  logic             RQG_n,
    input  logic             RZG_n,
    input  logic             RBHG_n,
    input  logic             RBLG_n,
    input  logic             RCG_n,
    output logic [WIDTH-1:0] RL_n,
    output logic             A_OVF,
    output logic             A_POSOVF,
    output logic             A_NEGOVF,
    output logic             BUS_MULTI
);

    localparam int HALF = WIDTH / 2;

    // L bits 1..WIDTH-2 belong to CLG1G, the top two bits to CLG2G
    localparam logic [WIDTH-1:0] L_LO_MASK = {2'b00, {(WIDTH-2){1'b1}}};
    localparam logic [WIDTH-1:0] L_HI_MASK = ~L_LO_MASK;
    localparam logic [WIDTH-1:0] B_LO_MASK = {{(WIDTH-HALF){1'b0}}, {HALF{1'b1}}};
    localparam logic [WIDTH-1:0] B_HI_MASK = ~B_LO_MASK;

    // supply pins carry no logic
    logic unused_pins;
    assign unused_pins = VCC ^ GND;

    logic [WIDTH-1:0] wl;
    logic [WIDTH-1:0] a_q, l_q, q_q, z_q, b_q;
    logic [WIDTH-1:0] a_d, l_d, q_d, z_d, b_d;
    logic [WIDTH-1:0] l_clr, l_wr, l_shift;
    logic [WIDTH-1:0] rl;
    logic [2:0]       src_cnt;
    logic             multi_d;

    assign wl = ~WL_n;

    // WALSG path: WL bits 1-2 land in L bits 13-14
    always_comb begin
        l_shift = '0;
        l_shift[13:12] = wl[1:0];
    end

    // next-state: clear first, then OR in the write bus
    always_comb begin
        l_clr = (CLG1G ? L_LO_MASK : '0) | (CLG2G ? L_HI_MASK : '0);
        l_wr  = (!WLG_n ? wl : '0) | (!WALSG_n ? l_shift : '0);
        a_d = (CAG ? '0 : a_q) | (!WAG_n ? wl : '0);
        l_d = (l_q & ~l_clr) | l_wr;
        q_d = (CQG ? '0 : q_q) | (!WQG_n ? wl : '0);
        z_d = (CZG ? '0 : z_q) | (!WZG_n ? wl : '0);
        b_d = (CBG ? '0 : b_q) | (!WBG_n ? wl : '0);
    end

    // register bank state
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            a_q <= '0;
            l_q <= '0;
            q_q <= '0;
            z_q <= Z_RESET;
            b_q <= '0;
        end else begin
            a_q <= a_d;
            l_q <= l_d;
            q_q <= q_d;
            z_q <= z_d;
            b_q <= b_d;
        end
    end

    // read bus: wired-OR of every selected source, pre-edge values
    always_comb begin
        rl = '0;
        if (!RAG_n)  rl = rl | a_q;
        if (!RLG_n)  rl = rl | l_q;
        if (!RQG_n)  rl = rl | q_q;
        if (!RZG_n)  rl = rl | z_q;
        if (!RBHG_n) rl = rl | (b_q & B_HI_MASK);
        if (!RBLG_n) rl = rl | (b_q & B_LO_MASK);
        if (!RCG_n)  rl = rl | ~b_q;
        RL_n = ~rl;
    end

    // B halves together count as a single source
    always_comb begin
        src_cnt = 3'(!RAG_n) + 3'(!RLG_n) + 3'(!RQG_n) + 3'(!RZG_n)
                + 3'(!RCG_n) + 3'(!RBHG_n || !RBLG_n);
        multi_d = (src_cnt >= 3'd2);
    end

    // diagnostic flag for bus contention seen on the last edge
    always_ff @(posedge SIM_CLK or posedge SIM_RST) begin
        if (SIM_RST) begin
            BUS_MULTI <= 1'b0;
        end else begin
            BUS_MULTI <= multi_d;
        end
    end

    // overflow decode from the two top bits of A
    always_comb begin
        A_OVF    = a_q[WIDTH-1] ^ a_q[WIDTH-2];
        A_POSOVF = !a_q[WIDTH-1] && a_q[WIDTH-2];
        A_NEGOVF = a_q[WIDTH-1] && !a_q[WIDTH-2];
    end

endmodule

// File: tb/tb_central_register_bank.sv
// Scoreboard bench for central_register_bank: directed test-plan steps
// followed by random gate patterns against a behavioural model.
module tb_central_register_bank;

    typedef struct packed {
        logic ca, cq, cz, cb, cl1, cl2;
        logic wa, wl, wq, wz, wb, wals;
        logic ra, rl, rq, rz, rbh, rbl, rc;
        logic [15:0] bus;
    } gates_t;

    typedef struct packed {
        logic [15:0] rl_n;
        logic ovf, pos, neg, multi;
    } exp_t;

    logic        clk = 1'b0;
    logic        rst = 1'b1;
    logic [15:0] WL_n = 16'hFFFF;
    logic CAG = 0, CQG = 0, CZG = 0, CBG = 0, CLG1G = 0, CLG2G = 0;
    logic WAG_n = 1, WLG_n = 1, WQG_n = 1, WZG_n = 1, WBG_n = 1, WALSG_n = 1;
    logic RAG_n = 1, RLG_n = 1, RQG_n = 1, RZG_n = 1;
    logic RBHG_n = 1, RBLG_n = 1, RCG_n = 1;
    logic [15:0] RL_n;
    logic A_OVF, A_POSOVF, A_NEGOVF, BUS_MULTI;

    central_register_bank dut (
        .SIM_CLK(clk), .SIM_RST(rst), .VCC(1'b1), .GND(1'b0),
        .WL_n(WL_n),
        .CAG(CAG), .CQG(CQG), .CZG(CZG), .CBG(CBG),
        .CLG1G(CLG1G), .CLG2G(CLG2G),
        .WAG_n(WAG_n), .WLG_n(WLG_n), .WQG_n(WQG_n),
        .WZG_n(WZG_n), .WBG_n(WBG_n), .WALSG_n(WALSG_n),
        .RAG_n(RAG_n), .RLG_n(RLG_n), .RQG_n(RQG_n), .RZG_n(RZG_n),
        .RBHG_n(RBHG_n), .RBLG_n(RBLG_n), .RCG_n(RCG_n),
        .RL_n(RL_n), .A_OVF(A_OVF), .A_POSOVF(A_POSOVF),
        .A_NEGOVF(A_NEGOVF), .BUS_MULTI(BUS_MULTI)
    );

    always #5 clk = ~clk;

    // model state: index 0..4 = A, L, Q, Z, B
    logic [15:0] m [5];
    logic        m_multi;
    gates_t      cur;
    bit          cur_rst;
    exp_t        sbq [$];
    int          passed = 0;
    int          total = 0;

    function automatic void model_reset();
        m[0] = 0; m[1] = 0; m[2] = 0; m[3] = 16'o04000; m[4] = 0;
        m_multi = 0;
    endfunction

    function automatic int nsrc(gates_t g);
        return int'(g.ra) + int'(g.rl) + int'(g.rq) + int'(g.rz)
             + int'(g.rc) + int'(g.rbh | g.rbl);
    endfunction

    function automatic void model_edge(gates_t g);
        logic [15:0] clr, wr;
        m[0] = (g.ca ? 16'h0 : m[0]) | (g.wa ? g.bus : 16'h0);
        clr = 0;
        if (g.cl1) clr = clr | 16'h3FFF;
        if (g.cl2) clr = clr | 16'hC000;
        wr = g.wl ? g.bus : 16'h0;
        if (g.wals) begin
            wr[12] = wr[12] | g.bus[0];
            wr[13] = wr[13] | g.bus[1];
        end
        m[1] = (m[1] & ~clr) | wr;
        m[2] = (g.cq ? 16'h0 : m[2]) | (g.wq ? g.bus : 16'h0);
        m[3] = (g.cz ? 16'h0 : m[3]) | (g.wz ? g.bus : 16'h0);
        m[4] = (g.cb ? 16'h0 : m[4]) | (g.wb ? g.bus : 16'h0);
        m_multi = nsrc(g) >= 2;
    endfunction

    function automatic exp_t model_out(gates_t g);
        exp_t e;
        logic [15:0] r;
        r = 0;
        if (g.ra)  r |= m[0];
        if (g.rl)  r |= m[1];
        if (g.rq)  r |= m[2];
        if (g.rz)  r |= m[3];
        if (g.rbh) r |= m[4] & 16'hFF00;
        if (g.rbl) r |= m[4] & 16'h00FF;
        if (g.rc)  r |= ~m[4];
        e.rl_n  = ~r;
        e.ovf   = m[0][15] ^ m[0][14];
        e.pos   = !m[0][15] && m[0][14];
        e.neg   = m[0][15] && !m[0][14];
        e.multi = m_multi;
        return e;
    endfunction

    task automatic apply(gates_t g);
        WL_n = ~g.bus;
        CAG = g.ca; CQG = g.cq; CZG = g.cz; CBG = g.cb;
        CLG1G = g.cl1; CLG2G = g.cl2;
        WAG_n = !g.wa; WLG_n = !g.wl; WQG_n = !g.wq;
        WZG_n = !g.wz; WBG_n = !g.wb; WALSG_n = !g.wals;
        RAG_n = !g.ra; RLG_n = !g.rl; RQG_n = !g.rq; RZG_n = !g.rz;
        RBHG_n = !g.rbh; RBLG_n = !g.rbl; RCG_n = !g.rc;
    endtask

    // one cycle: retire last cycle's gates in the model, drive new ones
    task automatic step(gates_t g, bit do_rst);
        @(posedge clk);
        if (!cur_rst) model_edge(cur);
        #1;
        apply(g);
        rst = do_rst;
        if (do_rst) model_reset();
        cur = g;
        cur_rst = do_rst;
        sbq.push_back(model_out(g));
    endtask

    task automatic chk(string name, logic [15:0] act, logic [15:0] req);
        total++;
        if (act === req) passed++;
        else $display("FAIL %s: got %h expected %h", name, act, req);
    endtask

    // monitor: compare the DUT against the oldest pending expectation
    always @(negedge clk) begin
        if (sbq.size() > 0) begin
            exp_t e;
            e = sbq.pop_front();
            chk("rl_n", RL_n, e.rl_n);
            chk("a_ovf", 16'(A_OVF), 16'(e.ovf));
            chk("a_posovf", 16'(A_POSOVF), 16'(e.pos));
            chk("a_negovf", 16'(A_NEGOVF), 16'(e.neg));
            chk("bus_multi", 16'(BUS_MULTI), 16'(e.multi));
        end
    end

    gates_t g;
    gates_t idle;

    initial begin
        model_reset();
        cur = '0;
        cur_rst = 1;
        idle = '0;
        step(idle, 1);
        step(idle, 0);
        // Z reset value on the read bus
        g = idle; g.rz = 1; step(g, 0);
        // A = 4001: positive overflow
        g = idle; g.ca = 1; g.wa = 1; g.bus = 16'h4001; step(g, 0);
        g = idle; g.ra = 1; step(g, 0);
        // Q = 00F0, OR in 000F, then clear
        g = idle; g.cq = 1; g.wq = 1; g.bus = 16'h00F0; step(g, 0);
        g = idle; g.wq = 1; g.bus = 16'h000F; g.rq = 1; step(g, 0);
        g = idle; g.rq = 1; step(g, 0);
        g = idle; g.cq = 1; g.rq = 1; step(g, 0);
        g = idle; g.rq = 1; step(g, 0);
        // L split clears and low-shift write
        g = idle; g.wl = 1; g.bus = 16'hFFFF; step(g, 0);
        g = idle; g.cl1 = 1; g.rl = 1; step(g, 0);
        g = idle; g.cl2 = 1; g.wals = 1; g.bus = 16'h0003; g.rl = 1; step(g, 0);
        g = idle; g.rl = 1; step(g, 0);
        // B halves and complement
        g = idle; g.cb = 1; g.wb = 1; g.bus = 16'h1234; step(g, 0);
        g = idle; g.rbh = 1; step(g, 0);
        g = idle; g.rbl = 1; step(g, 0);
        g = idle; g.rbh = 1; g.rbl = 1; step(g, 0);
        g = idle; g.rc = 1; step(g, 0);
        // A|Q wired-OR and the contention flag
        g = idle; g.ca = 1; g.wa = 1; g.bus = 16'h0101; step(g, 0);
        g = idle; g.cq = 1; g.wq = 1; g.bus = 16'h1010; step(g, 0);
        g = idle; g.ra = 1; g.rq = 1; step(g, 0);
        g = idle; g.ra = 1; g.rq = 1; step(g, 0);
        g = idle; g.ra = 1; step(g, 0);
        g = idle; g.ra = 1; g.rq = 1; step(g, 0);
        // reset mid-sequence discards the gates and restores Z
        g = idle; g.ra = 1; g.rz = 1; g.wa = 1; g.bus = 16'h7777; step(g, 1);
        g = idle; g.rz = 1; step(g, 0);
        g = idle; g.ra = 1; step(g, 0);
        // random gate patterns
        for (int i = 0; i < 400; i++) begin
            g.ca = ($urandom_range(0, 3) == 0); g.cq = ($urandom_range(0, 3) == 0);
            g.cz = ($urandom_range(0, 3) == 0); g.cb = ($urandom_range(0, 3) == 0);
            g.cl1 = ($urandom_range(0, 3) == 0); g.cl2 = ($urandom_range(0, 3) == 0);
            g.wa = ($urandom_range(0, 3) == 0); g.wl = ($urandom_range(0, 3) == 0);
            g.wq = ($urandom_range(0, 3) == 0); g.wz = ($urandom_range(0, 3) == 0);
            g.wb = ($urandom_range(0, 3) == 0); g.wals = ($urandom_range(0, 3) == 0);
            g.ra = ($urandom_range(0, 3) == 0); g.rl = ($urandom_range(0, 3) == 0);
            g.rq = ($urandom_range(0, 3) == 0); g.rz = ($urandom_range(0, 3) == 0);
            g.rbh = ($urandom_range(0, 3) == 0); g.rbl = ($urandom_range(0, 3) == 0);
            g.rc = ($urandom_range(0, 5) == 0);
            g.bus = 16'($urandom);
            step(g, $urandom_range(0, 63) == 0);
        end
        step(idle, 0);
        // drain the scoreboard with a bounded wait
        for (int k = 0; k < 10 && sbq.size() > 0; k++) @(posedge clk);
        total++;
        if (sbq.size() == 0) passed++;
        else $display("FAIL drain: %0d pending expected 0", sbq.size());
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule
